// File: rtl/pio_cmd_sequencer.sv
// HPS PIO command sequencer: toggle handshake, engine launch/timeout.
// Optional CMD_STATS_EN adds a completed-START counter read by op4.
module pio_cmd_sequencer #(
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [31:0] cmd_word,
  output logic [15:0] status_word,
  output logic        eng_start,
  output logic [27:0] eng_arg,
  output logic        eng_abort,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [10:0] eng_result,
  output logic [15:0] hex_value
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    LAUNCH,
    RUN,
    RESP
  } state_t;

  localparam logic [31:0] TLAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_seen;
  logic [2:0]             op;
  logic [27:0]            operand;
  logic [31:0]            timer;
  logic [10:0]            result_q;
  logic                   ack_q;
  logic [2:0]             err_q;
  logic [10:0]            data_q;
  logic [2:0]             err_n;
  logic [10:0]            data_n;
`ifdef CMD_STATS_EN
  logic [10:0]            stats;
`endif

  assign req_s = sync_q[SYNC_STAGES-1];

  assign status_word = {ack_q, state != IDLE, err_q, data_q};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmd_word[31]};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      req_seen  <= 1'b0;
      op        <= 3'd0;
      operand   <= 28'd0;
      timer     <= 32'd0;
      result_q  <= 11'd0;
      ack_q     <= 1'b0;
      err_q     <= 3'd0;
      data_q    <= 11'd0;
      err_n     <= 3'd0;
      data_n    <= 11'd0;
      eng_start <= 1'b0;
      eng_arg   <= 28'd0;
      eng_abort <= 1'b0;
      hex_value <= 16'd0;
`ifdef CMD_STATS_EN
      stats     <= 11'd0;
`endif
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s != req_seen) begin
            req_seen <= req_s;
            op       <= cmd_word[30:28];
            operand  <= cmd_word[27:0];
            state    <= DECODE;
          end
        end
        DECODE: begin
          state  <= RESP;
          err_n  <= 3'd0;
          data_n <= data_q;
          unique case (1'b1)
            op == 3'd0: err_n <= 3'd0;
            op == 3'd1: begin
              if (eng_busy) begin
                err_n <= 3'd2;
              end else begin
                state     <= LAUNCH;
                eng_start <= 1'b1;
                eng_arg   <= operand;
              end
            end
            op == 3'd2: begin
              hex_value <= operand[15:0];
              data_n    <= operand[10:0];
            end
            op == 3'd3: data_n <= result_q;
`ifdef CMD_STATS_EN
            op == 3'd4: data_n <= stats;
`endif
            default: err_n <= 3'd1;
          endcase
        end
        LAUNCH: begin
          timer <= 32'd0;
          state <= RUN;
        end
        RUN: begin
          // Completion takes priority over a coincident timeout.
          if (eng_done) begin
            result_q <= eng_result;
            data_n   <= eng_result;
            err_n    <= 3'd0;
            state    <= RESP;
`ifdef CMD_STATS_EN
            if (stats != 11'h7FF) stats <= stats + 11'd1;
`endif
          end else if (timer == TLAST) begin
            eng_abort <= 1'b1;
            err_n     <= 3'd3;
            state     <= RESP;
          end else if (timer != 32'hFFFF_FFFF) begin
            timer <= timer + 32'd1;
          end
        end
        RESP: begin
          ack_q  <= req_seen;
          err_q  <= err_n;
          data_q <= data_n;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer: vector table plus
// hand-written launch, timeout and reset sequences.
module tb_pio_cmd_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cmd_word = 32'd0;
  logic [15:0] status_word;
  logic        eng_start;
  logic [27:0] eng_arg;
  logic        eng_abort;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic [10:0] eng_result = 11'd0;
  logic [15:0] hex_value;

  int   checks = 0;
  int   errors = 0;
  logic tog = 1'b0;

  pio_cmd_sequencer #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .cmd_word(cmd_word),
    .status_word(status_word),
    .eng_start(eng_start),
    .eng_arg(eng_arg),
    .eng_abort(eng_abort),
    .eng_busy(eng_busy),
    .eng_done(eng_done),
    .eng_result(eng_result),
    .hex_value(hex_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [27:0] arg;
    logic        busy;
    logic [2:0]  err;
    logic [10:0] data;
    logic [15:0] hex;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [27:0] arg);
    tog = ~tog;
    cmd_word = {tog, op, arg};
  endtask

  task automatic wait_ack(output bit started);
    int n;
    n = 0;
    started = 0;
    while (status_word[15] !== tog && n < 60) begin
      @(negedge clk);
      n++;
      if (eng_start) started = 1;
    end
    check("ack_in_time", 32'(n < 60), 32'd1);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(eng_start), 32'd1);
  endtask

  initial begin
    bit started;
    bit saw;
    int n;

    vecs[0] = '{3'd0, 28'h0000000, 1'b0, 3'd0, 11'h123, 16'h1234};
    vecs[1] = '{3'd2, 28'h00ABCDE, 1'b0, 3'd0, 11'h4DE, 16'hBCDE};
    vecs[2] = '{3'd3, 28'h0000000, 1'b0, 3'd0, 11'h123, 16'hBCDE};
    vecs[3] = '{3'd1, 28'h0000044, 1'b1, 3'd2, 11'h123, 16'hBCDE};
    vecs[4] = '{3'd6, 28'h0000001, 1'b0, 3'd1, 11'h123, 16'hBCDE};
    vecs[5] = '{3'd5, 28'h0000002, 1'b0, 3'd1, 11'h123, 16'hBCDE};
    vecs[6] = '{3'd7, 28'hFFFFFFF, 1'b0, 3'd1, 11'h123, 16'hBCDE};
`ifdef CMD_STATS_EN
    vecs[7] = '{3'd4, 28'h0000000, 1'b0, 3'd0, 11'd2, 16'hBCDE};
    vecs[8] = '{3'd2, 28'h0000800, 1'b0, 3'd0, 11'h000, 16'h0800};
    vecs[9] = '{3'd0, 28'h0000000, 1'b0, 3'd0, 11'h000, 16'h0800};
`else
    vecs[7] = '{3'd4, 28'h0000000, 1'b0, 3'd1, 11'h123, 16'hBCDE};
    vecs[8] = '{3'd2, 28'h0000800, 1'b0, 3'd0, 11'h000, 16'h0800};
    vecs[9] = '{3'd0, 28'h0000000, 1'b0, 3'd0, 11'h000, 16'h0800};
`endif

    repeat (3) @(negedge clk);
    check("rst_status", 32'(status_word), 32'h0);
    check("rst_hex", 32'(hex_value), 32'h0);
    check("rst_start", 32'(eng_start), 32'h0);
    check("rst_arg", 32'(eng_arg), 32'h0);
    rst_n = 1'b1;

    // Toggle bit still 0: not a new command.
    tog = 1'b0;
    cmd_word = 32'h2000_1234;
    repeat (8) @(negedge clk);
    check("no_tog_status", 32'(status_word), 32'h0);
    check("no_tog_hex", 32'(hex_value), 32'h0);

    // First SET_HEX, edge-exact latency.
    tog = 1'b1;
    cmd_word = 32'hA000_1234;
    repeat (2) @(negedge clk);
    check("lat_e2_busy", 32'(status_word[14]), 32'd0);
    @(negedge clk);
    check("lat_e3_busy", 32'(status_word[14]), 32'd1);
    @(negedge clk);
    check("lat_e4_hex", 32'(hex_value), 32'h1234);
    check("lat_e4_ack", 32'(status_word[15]), 32'd0);
    @(negedge clk);
    check("lat_e5_status", 32'(status_word), 32'h8234);

    // START with completion after ten cycles.
    issue(3'd1, 28'h55);
    wait_start();
    check("start_arg", 32'(eng_arg), 32'h55);
    @(negedge clk);
    check("start_pulse", 32'(eng_start), 32'd0);
    repeat (8) @(negedge clk);
    eng_done = 1'b1;
    eng_result = 11'h3FF;
    @(negedge clk);
    eng_done = 1'b0;
    eng_result = 11'h0;
    wait_ack(started);
    check("done_status", 32'(status_word), 32'h03FF);
    check("done_arg_held", 32'(eng_arg), 32'h55);

    // Timeout: abort TO+1 samples after the launch pulse.
    issue(3'd1, 28'h7);
    wait_start();
    n = 0;
    while (eng_abort !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("abort_latency", 32'(n), 32'(TO + 1));
    @(negedge clk);
    check("abort_pulse", 32'(eng_abort), 32'd0);
    wait_ack(started);
    check("timeout_status", 32'(status_word), 32'h9BFF);

    // Done on the terminal timer cycle wins over timeout.
    issue(3'd1, 28'h9);
    wait_start();
    saw = 0;
    repeat (TO) begin
      @(negedge clk);
      if (eng_abort) saw = 1;
    end
    eng_done = 1'b1;
    eng_result = 11'h123;
    @(negedge clk);
    eng_done = 1'b0;
    eng_result = 11'h0;
    n = 0;
    while (status_word[15] !== tog && n < 20) begin
      if (eng_abort) saw = 1;
      @(negedge clk);
      n++;
    end
    check("race_ack", 32'(status_word[15]), 32'(tog));
    check("race_no_abort", 32'(saw), 32'd0);
    check("race_status", 32'(status_word), 32'h0123);

    // Single-step command table.
    for (int i = 0; i < 10; i++) begin
      eng_busy = vecs[i].busy;
      issue(vecs[i].op, vecs[i].arg);
      wait_ack(started);
      eng_busy = 1'b0;
      check($sformatf("vec%0d_status", i), 32'(status_word),
            32'({tog, 1'b0, vecs[i].err, vecs[i].data}));
      check($sformatf("vec%0d_hex", i), 32'(hex_value),
            32'(vecs[i].hex));
      check($sformatf("vec%0d_nostart", i), 32'(started), 32'd0);
    end

    // Reset while the engine runs.
    issue(3'd1, 28'h11);
    wait_start();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    tog = 1'b0;
    cmd_word = 32'h0;
    #1;
    check("mid_rst_status", 32'(status_word), 32'h0);
    check("mid_rst_start", 32'(eng_start), 32'h0);
    check("mid_rst_abort", 32'(eng_abort), 32'h0);
    check("mid_rst_hex", 32'(hex_value), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(status_word), 32'h0);
    issue(3'd2, 28'h5A5);
    wait_ack(started);
    check("post_rst_status", 32'(status_word), 32'h85A5);
    check("post_rst_hex", 32'(hex_value), 32'h05A5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
